// File: rtl/axi_burst_splitter.sv
// axi_burst_splitter: turns one linear transfer (start address + byte count)
// into legal AXI AW/AR bursts (INCR or FIXED, <=256 beats, no 4 KB crossing),
// counts outstanding bursts, merges their responses and reports one status.
//
// Handshakes: every channel uses valid/ready semantics. A transfer happens
// on a rising clk edge where valid && ready. Valid is never withdrawn before
// it is accepted. Payload is held stable while valid && !ready. rsp_valid has
// no ready and is always accepted.
module axi_burst_splitter #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_byte_count,
  input  logic          req_fixed,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [AW-1:0] cmd_addr,
  output logic [7:0]    cmd_len,
  output logic [1:0]    cmd_burst,
  input  logic          rsp_valid,
  input  logic [1:0]    rsp_resp,
  output logic          done_valid,
  output logic [1:0]    done_resp,
  output logic [1:0]    dbg_state
);

  localparam int BPB = DW / 8;
  localparam int OFF = $clog2(BPB);
  localparam int RBW = 32 - OFF;
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;         // start address of the burst after the current command
  logic [RBW-1:0] rem_q, rem_d;           // beats left after the current command
  logic       fixed_q, fixed_d;
  logic [OCW-1:0] outst_q, outst_d;
  axi_resp_e  resp_q, resp_d;
  logic [AW-1:0]  cmd_addr_q, cmd_addr_d;
  logic [7:0]     cmd_len_q, cmd_len_d;
  axi_burst_e cmd_burst_q, cmd_burst_d;

  logic req_hs, cmd_hs, rsp_ok, misaligned;

  // Burst sizing inputs: the request itself in IDLE, the remaining work otherwise.
  logic [AW-1:0]  src_addr;
  logic [RBW-1:0] src_rem;
  logic           src_fixed;
  logic [12:0]    room_bytes;
  logic [12:0]    room_beats;
  logic [8:0]     cap;
  logic [8:0]     beats;
  logic [AW-1:0]  next_addr;
  logic [RBW-1:0] next_rem;

  function automatic axi_resp_e merge_resp(input axi_resp_e acc, input logic [1:0] r);
    if (acc == AXI_RESP_DECERR || r == 2'b11)      return AXI_RESP_DECERR;
    else if (acc == AXI_RESP_SLVERR || r == 2'b10) return AXI_RESP_SLVERR;
    else                                          return AXI_RESP_OKAY;
  endfunction

  assign req_ready  = (state_q == S_IDLE);
  assign cmd_valid  = (state_q == S_ISSUE) && (outst_q < OCW'(MAX_OUTSTANDING));
  assign cmd_addr   = cmd_addr_q;
  assign cmd_len    = cmd_len_q;
  assign cmd_burst  = cmd_burst_q;
  assign done_valid = (state_q == S_DONE);
  assign done_resp  = resp_q;
  assign dbg_state  = state_q;

  assign req_hs     = req_valid && req_ready;
  assign cmd_hs     = cmd_valid && cmd_ready;
  // A response with nothing outstanding is stray and dropped entirely.
  assign rsp_ok     = rsp_valid && (outst_q != '0);
  assign misaligned = (req_addr[OFF-1:0] != '0) || (req_byte_count[OFF-1:0] != '0);

  // Size the next burst: remaining beats, capped by burst type and 4 KB room.
  always_comb begin
    src_addr   = (state_q == S_IDLE) ? req_addr : addr_q;
    src_rem    = (state_q == S_IDLE) ? req_byte_count[31:OFF] : rem_q;
    src_fixed  = (state_q == S_IDLE) ? req_fixed : fixed_q;
    room_bytes = 13'h1000 - {1'b0, src_addr[11:0]};
    room_beats = room_bytes >> OFF;
    cap        = src_fixed ? 9'd16 : 9'd256;
    if (!src_fixed && (room_beats < 13'(cap))) cap = room_beats[8:0];
    beats      = (src_rem < RBW'(cap)) ? src_rem[8:0] : cap;
    next_addr  = src_fixed ? src_addr : src_addr + (AW'(beats) << OFF);
    next_rem   = src_rem - RBW'(beats);
  end

  // Outstanding-burst credit counter; simultaneous issue and response cancel.
  always_comb begin
    outst_d = outst_q;
    if (cmd_hs && !rsp_ok)      outst_d = outst_q + OCW'(1);
    else if (!cmd_hs && rsp_ok) outst_d = outst_q - OCW'(1);
  end

  // Next-state and command/status register updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    fixed_d     = fixed_q;
    resp_d      = resp_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    cmd_burst_d = cmd_burst_q;

    if (rsp_ok) resp_d = merge_resp(resp_q, rsp_resp);

    case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          resp_d  = AXI_RESP_OKAY;
          fixed_d = req_fixed;
          if (req_byte_count == '0) begin
            state_d = S_DONE;
          end else if (misaligned) begin
            resp_d  = AXI_RESP_SLVERR;
            state_d = S_DONE;
          end else begin
            state_d     = S_ISSUE;
            cmd_addr_d  = req_addr;
            cmd_len_d   = 8'(beats - 9'd1);
            cmd_burst_d = req_fixed ? AXI_BURST_FIXED : AXI_BURST_INCR;
            addr_d      = next_addr;
            rem_d       = next_rem;
          end
        end
      end
      S_ISSUE: begin
        if (cmd_hs) begin
          if (rem_q == '0) begin
            state_d = S_DRAIN;
          end else begin
            cmd_addr_d = addr_q;
            cmd_len_d  = 8'(beats - 9'd1);
            addr_d     = next_addr;
            rem_d      = next_rem;
          end
        end
      end
      S_DRAIN: begin
        if (outst_d == '0) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      fixed_q     <= 1'b0;
      outst_q     <= '0;
      resp_q      <= AXI_RESP_OKAY;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_burst_q <= AXI_BURST_INCR;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      fixed_q     <= fixed_d;
      outst_q     <= outst_d;
      resp_q      <= resp_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      cmd_burst_q <= cmd_burst_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Bench for axi_burst_splitter: directed cases plus randomized transfers,
// with the expected command list and merged status computed from the burst
// sizing rules by plain arithmetic.
module tb_axi_burst_splitter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_fixed;
  logic [31:0] req_addr, req_byte_count;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_burst;
  logic        rsp_valid;
  logic [1:0]  rsp_resp;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [1:0]  dbg_state;

  axi_burst_splitter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_byte_count(req_byte_count), .req_fixed(req_fixed),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
    .done_valid(done_valid), .done_resp(done_resp), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [41:0] exp_q[$];        // {addr, len, burst} in issue order
  logic [1:0]  rsp_plan[256];   // response for the k-th burst response
  int          rsp_prob;        // percent chance of a response per cycle
  int          rdy_mode;        // 0 always ready, 1 random, 2 stall 5 valid cycles

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sev(input logic [1:0] r);
    return (r == 2'b11) ? 2 : (r == 2'b10) ? 1 : 0;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    int s;
    s = (sev(a) > sev(b)) ? sev(a) : sev(b);
    return (s == 2) ? 2'b11 : (s == 1) ? 2'b10 : 2'b00;
  endfunction

  // Reference: split the transfer into commands and pick the initial status.
  task automatic build_model(input logic [31:0] addr, input logic [31:0] bytes,
                             input logic fixed, output int total, output logic [1:0] resp0);
    logic [31:0] a;
    int unsigned rem, room, b;
    exp_q.delete();
    total = 0;
    resp0 = 2'b00;
    if (bytes == 0) return;
    if ((addr % 4) != 0 || (bytes % 4) != 0) begin
      resp0 = 2'b10;
      return;
    end
    a   = addr;
    rem = bytes / 4;
    while (rem > 0) begin
      if (fixed) begin
        b = (rem < 16) ? rem : 16;
      end else begin
        room = (4096 - (a % 4096)) / 4;
        b = (rem < 256) ? rem : 256;
        if (room < b) b = room;
      end
      exp_q.push_back({a, 8'(b - 1), fixed ? 2'b00 : 2'b01});
      if (!fixed) a = a + 32'(b * 4);
      rem = rem - b;
      total++;
    end
  endtask

  // Driver + per-cycle checker for one transfer; abort_after>0 leaves it mid-flight.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] bytes,
                          input logic fixed, input int abort_after);
    int total, out_m, issued, nrsp, stall;
    logic [1:0] exp_resp;
    bit done_next, finished, hs, got_rsp, exp_v;
    build_model(addr, bytes, fixed, total, exp_resp);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    check("cmd_valid_idle", cmd_valid, 1'b0);
    req_valid = 1'b1; req_addr = addr; req_byte_count = bytes; req_fixed = fixed;
    cmd_ready = 1'b0; rsp_valid = 1'b0;
    done_next = (total == 0);
    finished = 1'b0;
    out_m = 0; issued = 0; nrsp = 0; stall = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
      if (abort_after != 0 && cyc == abort_after) return;
      if (done_next) begin
        check("done_valid", done_valid, 1'b1);
        check("done_resp", done_resp, exp_resp);
        check("req_ready_in_done", req_ready, 1'b0);
        finished = 1'b1;
        break;
      end
      check("done_quiet", done_valid, 1'b0);
      exp_v = (issued < total) && (out_m < MAXO);
      check("cmd_valid", cmd_valid, exp_v);
      if (cmd_valid && issued < total)
        check("cmd_fields", {cmd_addr, cmd_len, cmd_burst}, exp_q[0]);
      case (rdy_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = ($urandom_range(0, 99) < 60);
        default: cmd_ready = (stall >= 5);
      endcase
      if (rdy_mode == 2 && cmd_valid) stall++;
      hs = cmd_valid && cmd_ready && (issued < total);
      got_rsp = 1'b0;
      if (out_m > 0 && $urandom_range(0, 99) < rsp_prob) begin
        rsp_valid = 1'b1;
        rsp_resp  = rsp_plan[nrsp % 256];
        got_rsp   = 1'b1;
      end else if (out_m == 0 && $urandom_range(0, 99) < 10) begin
        rsp_valid = 1'b1;          // stray response, must be ignored
        rsp_resp  = 2'b11;
      end
      if (got_rsp) begin
        exp_resp = worst(exp_resp, rsp_resp);
        nrsp++;
        out_m--;
      end
      if (hs) begin
        void'(exp_q.pop_front());
        issued++;
        out_m++;
      end
      if (got_rsp && issued == total && out_m == 0) done_next = 1'b1;
    end
    if (!finished) check("timeout", 1'b0, 1'b1);
    @(negedge clk);
    check("req_ready_after", req_ready, 1'b1);
    check("done_low_after", done_valid, 1'b0);
  endtask

  task automatic plan_fill(input logic [1:0] r);
    for (int i = 0; i < 256; i++) rsp_plan[i] = r;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
    check({tag, "_cmd_addr"}, cmd_addr, 32'h0);
    check({tag, "_cmd_len"}, cmd_len, 8'h0);
    check({tag, "_cmd_burst"}, cmd_burst, 2'b01);
    check({tag, "_done_valid"}, done_valid, 1'b0);
    check({tag, "_done_resp"}, done_resp, 2'b00);
  endtask

  initial begin
    logic [31:0] a, n;
    // Reset
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_byte_count = '0; req_fixed = 1'b0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_resp = 2'b00;
    rsp_prob = 50; rdy_mode = 0; plan_fill(2'b00);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Directed sizing cases
    run_xfer(32'h1000, 1024, 1'b0, 0);
    run_xfer(32'h0FF0, 64, 1'b0, 0);
    run_xfer(32'h0000, 2048, 1'b0, 0);
    run_xfer(32'h2000, 80, 1'b1, 0);
    run_xfer(32'hFFFF_FF00, 512, 1'b0, 0);   // wraps past 2^32

    // Credits exhausted with responses mostly withheld
    rsp_prob = 5;
    run_xfer(32'h0, 4096, 1'b0, 0);
    rsp_prob = 50;

    // Stray responses while idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rsp_valid = 1'b1; rsp_resp = 2'b11;
    end
    @(negedge clk);
    rsp_valid = 1'b0;
    check("stray_req_ready", req_ready, 1'b1);
    check("stray_done", done_valid, 1'b0);
    run_xfer(32'h1000, 16, 1'b0, 0);

    // Error merge
    plan_fill(2'b00); rsp_plan[1] = 2'b10;
    run_xfer(32'h0, 3072, 1'b0, 0);
    plan_fill(2'b00); rsp_plan[0] = 2'b11; rsp_plan[2] = 2'b10;
    run_xfer(32'h0, 3072, 1'b0, 0);
    plan_fill(2'b01);
    run_xfer(32'h0, 3072, 1'b0, 0);
    plan_fill(2'b00);

    // Zero length and misaligned
    run_xfer(32'h1002, 16, 1'b0, 0);
    run_xfer(32'h1000, 0, 1'b0, 0);
    run_xfer(32'h1000, 6, 1'b1, 0);

    // Command stall
    rdy_mode = 2;
    run_xfer(32'h1000, 16, 1'b0, 0);
    rdy_mode = 0;

    // Reset mid-transfer
    rsp_prob = 0;
    run_xfer(32'h0, 4096, 1'b0, 3);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_prob = 50;
    run_xfer(32'h3000, 1024, 1'b0, 0);

    // Randomized transfers
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      rsp_prob = $urandom_range(20, 90);
      for (int i = 0; i < 256; i++) rsp_plan[i] = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = {$urandom_range(0, 32'hFFFFF), 12'h0} - 32'(4 * $urandom_range(0, 300));
        1:       a = $urandom & 32'hFFFF_FFFC;
        2:       a = $urandom;
        default: a = {$urandom_range(0, 15), 12'h0};
      endcase
      n = 32'(4 * $urandom_range(0, 1200));
      if ($urandom_range(0, 9) == 0) n = n + 32'($urandom_range(1, 3));
      run_xfer(a, n, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
